// File: rtl/freelist.sv
// -----------------------------------------------------------------------------
// freelist
//
// Physical register free list for the rename stage. A circular FIFO of the
// physical tags not currently named by the architectural map. Up to two tags
// leave per cycle towards the rename map write port, and up to two tags come
// back per cycle from retirement.
//
// Ports
//   clk         clock, all state updates on posedge
//   rst         synchronous active-high reset
//   alloc_req   per-slot request for a new tag (slot 0 is older)
//   alloc_gnt   every requested slot can be served this cycle (combinational)
//   alloc_tag   tag offered to each slot (combinational)
//   free_en     per-slot tag return from retirement
//   free_tag    tags being returned
//   free_count  registered occupancy, 0..DEPTH
//   free_ovf    sticky error: a return would have exceeded DEPTH
// -----------------------------------------------------------------------------
module freelist #(
   parameter  int NPHYS = 32,
   parameter  int NARCH = 16,
   parameter  int DEPTH = NPHYS - NARCH,
   localparam int TAGW  = $clog2(NPHYS),
   localparam int PW    = $clog2(DEPTH)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [1:0]           alloc_req,
   output logic                 alloc_gnt,
   output logic [1:0][TAGW-1:0] alloc_tag,
   input  logic [1:0]           free_en,
   input  logic [1:0][TAGW-1:0] free_tag,
   output logic [PW:0]          free_count,
   output logic                 free_ovf
);

   // Storage and pointers
   logic [TAGW-1:0] r_entry [DEPTH];
   logic [PW-1:0]   r_head;
   logic [PW-1:0]   r_tail;
   logic [PW:0]     r_count;
   logic            r_ovf;

   logic [1:0]      w_nalloc;
   logic [1:0]      w_nalloc_eff;
   logic [1:0]      w_nfree;
   logic [1:0]      w_nfree_eff;
   logic            w_gnt;
   logic            w_ovf;
   logic [PW-1:0]   w_head1;
   logic [PW-1:0]   w_tail1;
   logic [PW+1:0]   w_cnt_sum;
   logic [PW:0]     w_cnt_next;

   function automatic logic [1:0] popcnt2(input logic [1:0] v);
      return {1'b0, v[0]} + {1'b0, v[1]};
   endfunction

   // Allocation side: purely from registered state, so a tag freed this
   // cycle can never be handed out before the next cycle.
   always_comb begin
      w_nalloc     = popcnt2(alloc_req);
      w_gnt        = (r_count >= {{(PW-1){1'b0}}, w_nalloc});
      w_nalloc_eff = w_gnt ? w_nalloc : 2'd0;
      // Slot 1 skips past slot 0 only when slot 0 is actually asking.
      w_head1      = r_head + PW'(alloc_req[0]);
   end

   assign alloc_gnt    = w_gnt;
   assign alloc_tag[0] = r_entry[r_head];
   assign alloc_tag[1] = r_entry[w_head1];

   // Return side: the overflow test uses the granted allocation of the same
   // cycle, and is evaluated one bit wider than count so it cannot wrap.
   always_comb begin
      w_nfree     = popcnt2(free_en);
      w_cnt_sum   = {1'b0, r_count}
                    - {{PW{1'b0}}, w_nalloc_eff}
                    + {{PW{1'b0}}, w_nfree};
      w_ovf       = (w_cnt_sum > (PW+2)'(DEPTH));
      // A return that would overflow is dropped as a whole.
      w_nfree_eff = w_ovf ? 2'd0 : w_nfree;
      w_cnt_next  = r_count
                    - {{(PW-1){1'b0}}, w_nalloc_eff}
                    + {{(PW-1){1'b0}}, w_nfree_eff};
      w_tail1     = r_tail + PW'(free_en[0]);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_entry[i] <= TAGW'(NARCH + i);
         end
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= (PW+1)'(DEPTH);
         r_ovf   <= 1'b0;
      end else begin
         if (!w_ovf) begin
            if (free_en[0]) begin
               r_entry[r_tail] <= free_tag[0];
            end
            if (free_en[1]) begin
               r_entry[w_tail1] <= free_tag[1];
            end
         end
         r_head  <= r_head + PW'(w_nalloc_eff);
         r_tail  <= r_tail + PW'(w_nfree_eff);
         r_count <= w_cnt_next;
         if (w_ovf) begin
            r_ovf <= 1'b1;
         end
      end
   end

   assign free_count = r_count;
   assign free_ovf   = r_ovf;

endmodule

// File: tb/tb_freelist.sv
// -----------------------------------------------------------------------------
// tb_freelist
//
// Directed bench for freelist: a table of per-cycle stimulus with expected
// combinational outputs before the edge and registered outputs after it,
// followed by a hand-written bounded drain sequence.
// -----------------------------------------------------------------------------
module tb_freelist;

   logic            clk;
   logic            rst;
   logic [1:0]      alloc_req;
   logic            alloc_gnt;
   logic [1:0][4:0] alloc_tag;
   logic [1:0]      free_en;
   logic [1:0][4:0] free_tag;
   logic [4:0]      free_count;
   logic            free_ovf;

   int n_cmp = 0;
   int n_bad = 0;

   typedef struct {
      logic       rst;
      logic [1:0] req;
      logic [1:0] fen;
      logic [4:0] ft0;
      logic [4:0] ft1;
      logic       cg;
      logic       gnt;
      logic       c0;
      logic [4:0] t0;
      logic       c1;
      logic [4:0] t1;
      logic [4:0] cnt;
      logic       ovf;
   } vec_t;

   vec_t vecs[$];

   freelist #(.NPHYS(32), .NARCH(16)) dut (
      .clk        (clk),
      .rst        (rst),
      .alloc_req  (alloc_req),
      .alloc_gnt  (alloc_gnt),
      .alloc_tag  (alloc_tag),
      .free_en    (free_en),
      .free_tag   (free_tag),
      .free_count (free_count),
      .free_ovf   (free_ovf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
      $fatal(1);
   end

   task automatic chk(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, required %0d", name, act, exp);
      end
   endtask

   // Normal cycle row.
   task automatic A(input int req, input int fen, input int ft0, input int ft1,
                    input int gnt, input int c0, input int t0, input int c1, input int t1,
                    input int cnt, input int ovf);
      vec_t v;
      v.rst = 1'b0;       v.req = 2'(req);  v.fen = 2'(fen);
      v.ft0 = 5'(ft0);    v.ft1 = 5'(ft1);  v.cg  = 1'b1;
      v.gnt = 1'(gnt);    v.c0  = 1'(c0);   v.t0  = 5'(t0);
      v.c1  = 1'(c1);     v.t1  = 5'(t1);   v.cnt = 5'(cnt);
      v.ovf = 1'(ovf);
      vecs.push_back(v);
   endtask

   // Reset row: combinational outputs not checked, state after edge is.
   task automatic R(input int req, input int fen, input int ft0, input int ft1);
      vec_t v;
      v.rst = 1'b1;       v.req = 2'(req);  v.fen = 2'(fen);
      v.ft0 = 5'(ft0);    v.ft1 = 5'(ft1);  v.cg  = 1'b0;
      v.gnt = 1'b0;       v.c0  = 1'b0;     v.t0  = 5'd0;
      v.c1  = 1'b0;       v.t1  = 5'd0;     v.cnt = 5'd16;
      v.ovf = 1'b0;
      vecs.push_back(v);
   endtask

   initial begin
      int ngr;
      bit done;

      rst       = 1'b1;
      alloc_req = 2'b00;
      free_en   = 2'b00;
      free_tag  = '0;

      // Reset, idle view, drain with 2-wide allocation, then empty behaviour
      R(0, 0, 0, 0);
      for (int k = 0; k < 8; k++)
         A(3, 0, 0, 0, 1, 1, 16 + 2*k, 1, 17 + 2*k, 14 - 2*k, 0);
      A(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      A(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
      // Empty with same-cycle free: no bypass, tags usable next cycle
      A(1, 3, 5, 9, 0, 0, 0, 0, 0, 2, 0);
      A(3, 0, 0, 0, 1, 1, 5, 1, 9, 0, 0);

      // Single-slot ordering
      R(0, 0, 0, 0);
      A(2, 0, 0, 0, 1, 0, 0, 1, 16, 15, 0);
      A(3, 0, 0, 0, 1, 1, 17, 1, 18, 13, 0);

      // Wrap-around of both pointers
      R(0, 0, 0, 0);
      for (int k = 0; k < 6; k++)
         A(3, 0, 0, 0, 1, 1, 16 + 2*k, 1, 17 + 2*k, 14 - 2*k, 0);
      for (int k = 0; k < 6; k++)
         A(0, 3, 2*k, 2*k + 1, 1, 0, 0, 0, 0, 6 + 2*k, 0);
      A(3, 0, 0, 0, 1, 1, 28, 1, 29, 14, 0);
      A(3, 0, 0, 0, 1, 1, 30, 1, 31, 12, 0);
      for (int k = 0; k < 6; k++)
         A(3, 0, 0, 0, 1, 1, 2*k, 1, 2*k + 1, 10 - 2*k, 0);
      A(0, 3, 20, 21, 1, 0, 0, 0, 0, 2, 0);
      A(3, 3, 22, 23, 1, 1, 20, 1, 21, 2, 0);
      A(1, 3, 24, 25, 1, 1, 22, 0, 0, 3, 0);
      A(3, 0, 0, 0, 1, 1, 23, 1, 24, 1, 0);
      A(2, 0, 0, 0, 1, 0, 0, 1, 25, 0, 0);

      // Overflow: reset overriding active inputs, dropped return, sticky flag
      R(3, 3, 7, 8);
      A(0, 1, 3, 0, 1, 0, 0, 0, 0, 16, 1);
      A(1, 0, 0, 0, 1, 1, 16, 0, 0, 15, 1);
      A(0, 0, 0, 0, 1, 0, 0, 0, 0, 15, 1);
      R(0, 0, 0, 0);
      A(1, 1, 3, 0, 1, 1, 16, 0, 0, 16, 0);
      A(3, 3, 4, 6, 1, 1, 17, 1, 18, 16, 0);
      A(1, 3, 1, 2, 1, 1, 19, 0, 0, 15, 1);

      foreach (vecs[i]) begin
         @(negedge clk);
         rst         = vecs[i].rst;
         alloc_req   = vecs[i].req;
         free_en     = vecs[i].fen;
         free_tag[0] = vecs[i].ft0;
         free_tag[1] = vecs[i].ft1;
         #1;
         if (vecs[i].cg) chk($sformatf("v%0d alloc_gnt", i), int'(alloc_gnt), int'(vecs[i].gnt));
         if (vecs[i].c0) chk($sformatf("v%0d alloc_tag0", i), int'(alloc_tag[0]), int'(vecs[i].t0));
         if (vecs[i].c1) chk($sformatf("v%0d alloc_tag1", i), int'(alloc_tag[1]), int'(vecs[i].t1));
         @(posedge clk);
         #1;
         chk($sformatf("v%0d free_count", i), int'(free_count), int'(vecs[i].cnt));
         chk($sformatf("v%0d free_ovf", i), int'(free_ovf), int'(vecs[i].ovf));
      end

      // Hand-written: single-slot drain from reset until the grant drops,
      // bounded so a stuck grant cannot hang the run.
      @(negedge clk);
      rst       = 1'b1;
      alloc_req = 2'b00;
      free_en   = 2'b00;
      @(posedge clk);
      #1;
      chk("drain reset count", int'(free_count), 16);
      ngr  = 0;
      done = 1'b0;
      for (int c = 0; c < 40 && !done; c++) begin
         @(negedge clk);
         rst       = 1'b0;
         alloc_req = 2'b01;
         #1;
         if (!alloc_gnt) begin
            done = 1'b1;
         end else begin
            chk($sformatf("drain tag %0d", ngr), int'(alloc_tag[0]), 16 + ngr);
            ngr++;
            @(posedge clk);
         end
      end
      if (!done) begin
         n_cmp++;
         n_bad++;
         $display("FAIL drain bound: grant still high after 40 cycles, required drop after 16");
      end
      chk("drain grants", ngr, 16);
      chk("drain final count", int'(free_count), 0);
      @(negedge clk);
      alloc_req = 2'b00;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/freelist.md
# freelist

Physical register free list for the rename stage. Holds the physical tags not currently named by the architectural map, hands up to two tags per cycle to the rename map write port, and reclaims up to two tags per cycle from retirement. A circular FIFO with 2-wide enqueue/dequeue, an occupancy count, and a sticky overflow error flag.

## Interface

- NPHYS, 32: physical register count; TAGW = $clog2(NPHYS) = 5.
- NARCH, 16: architectural register count; physical tags 0..NARCH-1 are mapped at reset.
- DEPTH, NPHYS-NARCH = 16: FIFO entries; must be a power of 2; pointer width PW = $clog2(DEPTH) = 4.

Ports:

- clk  in  1  clock; all state updates on posedge.
- rst  in  1  synchronous, active-high reset.
- alloc_req  in  [1:0]  per-slot request for a new physical tag (slot 0 is older).
- alloc_gnt  out  1  all requested slots can be served this cycle; combinational.
- alloc_tag  out  [1:0][TAGW-1:0]  tag offered to each slot; combinational.
- free_en  in  [1:0]  per-slot tag return from retirement.
- free_tag  in  [1:0][TAGW-1:0]  tags returned.
- free_count  out  [PW:0]  registered occupancy, 0..DEPTH.
- free_ovf  out  1  sticky error: a return would exceed DEPTH.

## Operation

- Storage: DEPTH x TAGW entries, head pointer (next tag to allocate), tail pointer (next write slot), count register. Pointers are PW bits and wrap modulo DEPTH.
- Reset: entry[i] = NARCH+i (16..31), head = 0, tail = 0, count = DEPTH, free_ovf = 0.
- Allocation ordering: slot 0 takes entry[head] if alloc_req[0]. Slot 1 takes entry[head + alloc_req[0]].
  - req = 2'b10: alloc_tag[1] = entry[head].
  - req = 2'b11: alloc_tag[0] = entry[head], alloc_tag[1] = entry[head+1].
  - alloc_tag for a non-requesting slot is don't-care; it is driven with the same formula.
- nalloc = popcount(alloc_req); alloc_gnt = (count >= nalloc).
  - alloc_req = 0 gives alloc_gnt = 1.
- All-or-nothing: when alloc_gnt = 0, no tag is consumed, head does not move, and the requester stalls.
- When alloc_gnt = 1: head <= head + nalloc.
- Return: free_en[0] writes entry[tail] = free_tag[0]. Then free_en[1] writes entry[tail + free_en[0]] = free_tag[1]. nfree = popcount(free_en); tail <= tail + nfree.
- Overflow: if count - nalloc_eff + nfree > DEPTH, where nalloc_eff = alloc_gnt ? nalloc : 0, then:
  - the whole return is dropped (no write, tail unchanged);
  - free_ovf <= 1 and holds until rst;
  - allocation that cycle still proceeds.
- count <= count - nalloc_eff + nfree_eff. Compute in PW+2 bits to avoid wrap.
- No bypass: a tag returned in cycle N is allocatable from cycle N+1 at the earliest. alloc_gnt uses the registered count only.
- Tag values are not checked for duplicates or range. Correctness of the returned tags is the retirement logic's responsibility.

## Timing

- alloc_tag and alloc_gnt are combinational from head, count, entries, and alloc_req. Consumption takes effect at the next posedge.
- free_count and free_ovf are registered. Reset values are DEPTH (16) and 0.
- Simultaneous alloc and free in one cycle are independent. Head and tail never collide on a live entry, because frees are bounded by DEPTH - count + nalloc_eff and allocs are bounded by count.
- Empty (count = 0): alloc_gnt = 1 only for alloc_req = 0. Frees in the same cycle are accepted.
- Full (count = 16): any free without a matching granted allocation sets free_ovf.
- rst asserted mid-operation overrides all inputs in that cycle; state returns to reset values at that posedge.

## Test plan

- Reset, then check idle outputs. Expect free_count = 16, free_ovf = 0, alloc_tag = {17, 16}, and alloc_gnt = 1 for req = 2'b11.
- Drain: 8 cycles of req = 2'b11. Slots get (16,17), (18,19) … (30,31), and free_count falls to 0. Then req = 2'b01 gives gnt = 0, and req = 2'b00 gives gnt = 1.
- Single-slot ordering: after reset, req = 2'b10 gives alloc_tag[1] = 16 and next cycle free_count = 15. Then req = 2'b11 gives (17,18).
- Empty plus same-cycle free: at count 0, free_en = 2'b11 with tags (5,9) and req = 2'b01 gives gnt = 0. Next cycle, req = 2'b11 gives gnt = 1 with tags (5,9), and count returns to 0.
- Wrap-around: allocate 12, free 12 tags (0..11), then allocate 16 over further cycles. Tags come out in order 28..31, 0..11, verifying both pointers wrapped. free_ovf stays 0.
- Overflow: at count 16, free_en = 2'b01 with req = 0 sets free_ovf = 1 and count stays 16. Same stimulus with req = 2'b01 granted gives count 16 and no flag. Asserting rst clears the flag.
